mpu_det_seq: RTL and testbench

MPU_DET_SEQ -- requirements
Module: mpu_det_seq

---
 rtl/mpu_det_seq.sv | 171 +++++++++++++++++
 tb/tb_mpu_det_seq.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mpu_det_seq.sv
// Sequential determinant of an n x n signed matrix (n <= N_MAX) via fraction-free Bareiss elimination.
// Latency: 2n-1 cycles from accept to done for n>=2; 1 cycle for n=1 or a bad size; 2k+2 on a zero pivot column k.
// Backpressure: none; start is only sampled in IDLE and outside the done cycle, so requests while busy are dropped.
module mpu_det_seq #(
    parameter int N_MAX  = 5,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 48
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [3:0]                    size,
    input  logic [N_MAX*N_MAX*DATA_W-1:0] matrix,
    output logic                          busy,
    output logic                          done,
    output logic [DATA_W-1:0]             result,
    output logic [ACC_W-1:0]              result_full,
    output logic                          overflow,
    output logic                          singular,
    output logic                          size_err
);
    localparam int IW = (N_MAX > 1) ? $clog2(N_MAX) : 1;
    localparam int PW = 2 * ACC_W;
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'((2 ** (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ~MAX_V;

    typedef enum logic [1:0] {IDLE, PIVOT, ELIM, FIN} state_t;

    state_t                  state;
    logic signed [ACC_W-1:0] a      [N_MAX][N_MAX];
    logic signed [ACC_W-1:0] a_elim [N_MAX][N_MAX];
    logic signed [ACC_W-1:0] prev;
    logic signed [ACC_W-1:0] det;
    logic [3:0]              n;
    logic [IW-1:0]           k;
    logic [IW-1:0]           last;
    logic [IW-1:0]           piv_idx;
    logic                    found;
    logic                    neg;
    logic                    zero_det;
    logic                    err;
    logic                    size_ok;

    function automatic logic signed [ACC_W-1:0] ext_in(input logic [DATA_W-1:0] v);
        return {{(ACC_W - DATA_W){v[DATA_W-1]}}, v};
    endfunction

    function automatic logic signed [PW-1:0] ext_acc(input logic signed [ACC_W-1:0] v);
        return {{ACC_W{v[ACC_W-1]}}, v};
    endfunction

    assign size_ok = (size != 4'd0) && (int'(size) <= N_MAX);

    // Bareiss step for pivot k: trailing (n-1-k)^2 block updated in parallel, exact signed division by prev
    always_comb begin
        for (int i = 0; i < N_MAX; i++) begin
            for (int j = 0; j < N_MAX; j++) begin
                a_elim[i][j] = a[i][j];
                if (i > int'(k) && j > int'(k) && i < int'(n) && j < int'(n)) begin
                    a_elim[i][j] = ACC_W'((ext_acc(a[k][k]) * ext_acc(a[i][j])
                                         - ext_acc(a[i][k]) * ext_acc(a[k][j])) / ext_acc(prev));
                end
            end
        end
    end

    // First row below k with a nonzero entry in column k, used when the pivot is zero
    always_comb begin
        found   = 1'b0;
        piv_idx = k;
        for (int i = 0; i < N_MAX; i++) begin
            if (!found && i > int'(k) && i < int'(n) && a[i][k] != '0) begin
                found   = 1'b1;
                piv_idx = IW'(i);
            end
        end
    end

    // Determinant as seen in FIN: signed last pivot, or zero for a bad size or an empty pivot column
    always_comb begin
        det = a[last][last];
        if (neg) begin
            det = -a[last][last];
        end
        if (err || zero_det) begin
            det = '0;
        end
    end

    // Control FSM, working matrix and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            result_full <= '0;
            overflow    <= 1'b0;
            singular    <= 1'b0;
            size_err    <= 1'b0;
            prev        <= ACC_W'(1);
            n           <= '0;
            k           <= '0;
            last        <= '0;
            neg         <= 1'b0;
            zero_det    <= 1'b0;
            err         <= 1'b0;
            for (int r = 0; r < N_MAX; r++) begin
                for (int c = 0; c < N_MAX; c++) begin
                    a[r][c] <= '0;
                end
            end
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // done high means the previous result is only now visible; skip this cycle's start
                    if (start && !done) begin
                        for (int r = 0; r < N_MAX; r++) begin
                            for (int c = 0; c < N_MAX; c++) begin
                                a[r][c] <= ext_in(matrix[DATA_W*(c+N_MAX*r) +: DATA_W]);
                            end
                        end
                        n        <= size;
                        k        <= '0;
                        last     <= size_ok ? IW'(size - 4'd1) : '0;
                        prev     <= ACC_W'(1);
                        neg      <= 1'b0;
                        zero_det <= 1'b0;
                        err      <= !size_ok;
                        busy     <= 1'b1;
                        state    <= (size_ok && size >= 4'd2) ? PIVOT : FIN;
                    end
                end
                PIVOT: begin
                    if (a[k][k] != '0) begin
                        state <= ELIM;
                    end else if (found) begin
                        for (int c = 0; c < N_MAX; c++) begin
                            a[k][c]       <= a[piv_idx][c];
                            a[piv_idx][c] <= a[k][c];
                        end
                        neg   <= ~neg;
                        state <= ELIM;
                    end else begin
                        zero_det <= 1'b1;
                        state    <= FIN;
                    end
                end
                ELIM: begin
                    a     <= a_elim;
                    prev  <= a[k][k];
                    k     <= k + 1'b1;
                    state <= (int'(k) + 2 < int'(n)) ? PIVOT : FIN;
                end
                FIN: begin
                    result      <= det[DATA_W-1:0];
                    result_full <= det;
                    overflow    <= !err && (det > MAX_V || det < MIN_V);
                    singular    <= !err && (det == '0);
                    size_err    <= err;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mpu_det_seq.sv
// Directed determinant vectors with a scoreboard queue and an independent done monitor.
// Latency is measured from the accepting edge to the done pulse.
// Each request also probes start-while-busy and start-during-done, which must both be dropped.
module tb_mpu_det_seq;
    localparam int N_MAX  = 5;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 48;

    logic                          clk;
    logic                          rst_n;
    logic                          start;
    logic [3:0]                    size;
    logic [N_MAX*N_MAX*DATA_W-1:0] matrix;
    logic                          busy;
    logic                          done;
    logic [DATA_W-1:0]             result;
    logic [ACC_W-1:0]              result_full;
    logic                          overflow;
    logic                          singular;
    logic                          size_err;

    typedef struct {
        string       name;
        logic [7:0]  res;
        longint      full;
        bit          ovf;
        bit          sing;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   cyc;
    int   n_chk;
    int   n_fail;

    mpu_det_seq #(.N_MAX(N_MAX), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .size        (size),
        .matrix      (matrix),
        .busy        (busy),
        .done        (done),
        .result      (result),
        .result_full (result_full),
        .overflow    (overflow),
        .singular    (singular),
        .size_err    (size_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic fill(input logic [7:0] v);
        for (int i = 0; i < N_MAX * N_MAX; i++) begin
            matrix[DATA_W*i +: DATA_W] = v;
        end
    endtask

    task automatic set_el(input int r, input int c, input int v);
        logic [7:0] b;
        b = 8'(v);
        matrix[DATA_W*(c+N_MAX*r) +: DATA_W] = b;
    endtask

    // Monitor: every done pulse must match the oldest outstanding request
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done_queue_size", sb.size(), 1);
            end else begin
                mon_e = sb.pop_front();
                chk({mon_e.name, "_result"},   result, mon_e.res);
                chk({mon_e.name, "_full"},     longint'($signed(result_full)), mon_e.full);
                chk({mon_e.name, "_overflow"}, overflow, mon_e.ovf);
                chk({mon_e.name, "_singular"}, singular, mon_e.sing);
                chk({mon_e.name, "_size_err"}, size_err, mon_e.err);
                chk({mon_e.name, "_latency"},  cyc - mon_e.acc, mon_e.lat);
            end
        end
    end

    task automatic run(input string nm, input int n, input logic [7:0] res, input longint full,
                       input bit ovf, input bit sing, input bit err, input int lat);
        exp_t e;
        bit   seen;
        @(negedge clk);
        size  = 4'(n);
        start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        e.name = nm;
        e.res  = res;
        e.full = full;
        e.ovf  = ovf;
        e.sing = sing;
        e.err  = err;
        e.lat  = lat;
        e.acc  = cyc;
        sb.push_back(e);
        chk({nm, "_busy"}, busy, 1);
        // Disturb the inputs and request again while busy; neither may matter
        matrix = ~matrix;
        size   = 4'd7;
        start  = 1'b1;
        seen   = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) seen = 1'b1;
        end
        chk({nm, "_done_seen"}, seen, 1);
        if (seen) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            chk({nm, "_start_in_done_dropped"}, busy, 0);
            chk({nm, "_done_one_cycle"}, done, 0);
            chk({nm, "_result_hold"}, result, res);
        end
    endtask

    initial begin
        cyc    = 0;
        n_chk  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        size   = 4'd0;
        matrix = '0;
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_full", longint'($signed(result_full)), 0);
        chk("rst_flags", {overflow, singular, size_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        fill(8'h55); set_el(0,0,3); set_el(0,1,1); set_el(1,0,4); set_el(1,1,2);
        run("m2", 2, 8'h02, 2, 0, 0, 0, 3);

        fill(8'h55); set_el(0,0,2); set_el(0,1,0); set_el(0,2,1);
        set_el(1,0,1); set_el(1,1,3); set_el(1,2,2);
        set_el(2,0,1); set_el(2,1,1); set_el(2,2,2);
        run("m3", 3, 8'h06, 6, 0, 0, 0, 5);

        fill(8'h55); set_el(0,0,0); set_el(0,1,1); set_el(1,0,1); set_el(1,1,0);
        run("swap", 2, 8'hFF, -1, 0, 0, 0, 3);

        fill(8'h00);
        for (int i = 0; i < 5; i++) set_el(i, i, 100);
        run("diag5", 5, 8'h00, 64'sd10000000000, 1, 0, 0, 9);

        fill(8'h55); set_el(0,0,1); set_el(0,1,2); set_el(0,2,3);
        set_el(1,0,2); set_el(1,1,4); set_el(1,2,6);
        set_el(2,0,1); set_el(2,1,1); set_el(2,2,1);
        run("sing3", 3, 8'h00, 0, 0, 1, 0, 5);

        fill(8'h11);
        run("size6", 6, 8'h00, 0, 0, 0, 1, 1);
        run("size0", 0, 8'h00, 0, 0, 0, 1, 1);

        fill(8'h55); set_el(0,0,-5);
        run("n1", 1, 8'hFB, -5, 0, 0, 0, 1);

        fill(8'h55); set_el(0,0,0); set_el(0,1,1); set_el(0,2,2);
        set_el(1,0,0); set_el(1,1,3); set_el(1,2,4);
        set_el(2,0,0); set_el(2,1,5); set_el(2,2,6);
        run("exit0", 3, 8'h00, 0, 0, 1, 0, 2);

        fill(8'h55); set_el(0,0,1); set_el(0,1,2); set_el(0,2,3);
        set_el(1,0,2); set_el(1,1,4); set_el(1,2,6);
        set_el(2,0,3); set_el(2,1,6); set_el(2,2,9);
        run("exit1", 3, 8'h00, 0, 0, 1, 0, 4);

        fill(8'h55); set_el(0,0,127); set_el(0,1,0); set_el(1,0,0); set_el(1,1,1);
        run("p127", 2, 8'h7F, 127, 0, 0, 0, 3);

        fill(8'h55); set_el(0,0,-128); set_el(0,1,0); set_el(1,0,0); set_el(1,1,1);
        run("m128", 2, 8'h80, -128, 0, 0, 0, 3);

        fill(8'h55); set_el(0,0,64); set_el(0,1,0); set_el(1,0,0); set_el(1,1,2);
        run("p128", 2, 8'h80, 128, 1, 0, 0, 3);

        fill(8'h00); set_el(0,0,2); set_el(1,2,3); set_el(2,1,1); set_el(3,3,1);
        run("swap4", 4, 8'hFA, -6, 0, 0, 0, 7);

        fill(8'h55); set_el(0,0,100); set_el(0,1,0); set_el(0,2,0);
        set_el(1,0,0); set_el(1,1,-2); set_el(1,2,0);
        set_el(2,0,0); set_el(2,1,0); set_el(2,2,1);
        run("negovf", 3, 8'h38, -200, 1, 0, 0, 5);

        // Abort a size-5 run in its second ELIM; nothing may complete afterwards
        fill(8'h00);
        for (int i = 0; i < 5; i++) set_el(i, i, 100);
        @(negedge clk);
        size  = 4'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_full", longint'($signed(result_full)), 0);
        chk("abort_flags", {overflow, singular, size_err}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);

        fill(8'h55); set_el(0,0,3); set_el(0,1,1); set_el(1,0,4); set_el(1,1,2);
        run("post_rst", 2, 8'h02, 2, 0, 0, 0, 3);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
